// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures operands on start and walks one
// full_adder cell over them LSB first, one bit per clock, then pulses done.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start; sum_o/c_out_o hold the last result
// RUN   | one operand bit consumed per edge, LSB first
// DONE  | result registered; done_o pulses for this one cycle
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             c_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic             fa_sum;
  logic             fa_c_out;
  logic [WIDTH-1:0] acc_shift;

  full_adder u_fa (
    .a     (sh_a_q[0]),
    .b     (sh_b_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  // New bit enters at the MSB; written with shifts so WIDTH=1 needs no special case.
  assign acc_shift = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sh_a_d  = op_a_i;
          sh_b_d  = op_b_i;
          carry_d = c_in_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_shift;
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        carry_d = fa_c_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = acc_shift;
          c_out_d = fa_c_out;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign sum_o   = sum_q;
  assign c_out_o = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + randomized bench for serial_add_ctrl at WIDTH=8 and WIDTH=1;
// expected results come from plain integer addition of the captured operands.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, ci1, busy1, done1, sum1, co1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8),
    .op_a_i(a8), .op_b_i(b8), .c_in_i(ci8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .c_out_o(co8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1),
    .op_a_i(a1), .op_b_i(b1), .c_in_i(ci1),
    .busy_o(busy1), .done_o(done1), .sum_o(sum1), .c_out_o(co1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation from IDLE; operands are scrambled after the accepting edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(ci);
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("busy_after_accept", 32'(busy8), 32'd1);
    chk("done_after_accept", 32'(done8), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      tick();
      chk("busy_run", 32'(busy8), 32'd1);
      chk("done_timing", 32'(done8), (k == 8) ? 32'd1 : 32'd0);
    end
    chk("sum8", 32'(sum8), 32'(exp[7:0]));
    chk("cout8", 32'(co8), 32'(exp[8]));
    tick();
    chk("done_one_cycle", 32'(done8), 32'd0);
    chk("busy_cleared", 32'(busy8), 32'd0);
    chk("sum8_held", 32'(sum8), 32'(exp[7:0]));
    chk("cout8_held", 32'(co8), 32'(exp[8]));
  endtask

  task automatic op1(input logic a, input logic b, input logic ci);
    logic [1:0] exp;
    exp = 2'(a) + 2'(b) + 2'(ci);
    a1 = a; b1 = b; ci1 = ci; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    a1 = ~a; b1 = ~b; ci1 = ~ci;
    chk("w1_busy_accept", 32'(busy1), 32'd1);
    chk("w1_done_early", 32'(done1), 32'd0);
    tick();
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_sum", 32'(sum1), 32'(exp[0]));
    chk("w1_cout", 32'(co1), 32'(exp[1]));
    tick();
    chk("w1_done_clear", 32'(done1), 32'd0);
    chk("w1_busy_clear", 32'(busy1), 32'd0);
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] last;
    logic [8:0] e;
    int         p;

    // Reset with start asserted: nothing may begin.
    rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
    a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(co8), 32'd0);
    chk("rst_w1_busy", 32'(busy1), 32'd0);
    chk("rst_w1_sum", 32'(sum1), 32'd0);
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    tick();
    chk("idle_busy", 32'(busy8), 32'd0);

    op8(8'h0F, 8'h01, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
    op8(8'hA5, 8'h5A, 1'b0);

    // start held high: accepts every WIDTH+2 edges, only at IDLE edges.
    p = 10;
    last = 9'h0FF;
    start8 = 1'b1;
    for (int t = 0; t < 3 * p; t++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      if (t % p == 0) q.push_back(9'(a8) + 9'(b8) + 9'(ci8));
      tick();
      chk("hold_done", 32'(done8), (t % p == 8) ? 32'd1 : 32'd0);
      chk("hold_busy", 32'(busy8), (t % p == 9) ? 32'd0 : 32'd1);
      if (t % p == 8) begin
        if (q.size() != 0) last = q.pop_front();
      end
      chk("hold_sum", 32'(sum8), 32'(last[7:0]));
      chk("hold_cout", 32'(co8), 32'(last[8]));
    end
    start8 = 1'b0;

    // Reset on the 4th RUN edge aborts the operation.
    a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(co8), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("abort_no_done", 32'(done8), 32'd0);
    end
    op8(8'h0F, 8'h01, 1'b0);

    for (int n = 0; n < 20; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Back-to-back: new start in the first IDLE cycle after done.
    e = 9'h000;
    op8(8'h00, 8'h00, 1'b0);
    chk("zero_sum", 32'(sum8), 32'(e[7:0]));

    for (int m = 0; m < 8; m++) begin
      op1(m[2], m[1], m[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencing controller that performs a WIDTH-bit addition by running one 1-bit full_adder cell over the operands, LSB first, one bit per clock.
- Captures the operands on a start handshake and steps the carry through a flip-flop.
- Returns the registered sum and carry-out with a one-cycle done pulse.
- Sits between a requester and the shared full_adder cell (ports a, b, c_in, sum, c_out), which it instantiates internally; trades latency for area versus a parallel ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- op_a  input  WIDTH  operand A, captured at the accepting edge
- op_b  input  WIDTH  operand B, captured at the accepting edge
- c_in  input  1  carry-in, captured at the accepting edge
- busy  output  1  high while an operation is in progress (state != IDLE)
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  registered result, held until next completion
- c_out  output  1  registered final carry, held until next completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. At the rst edge: state=IDLE, busy=0, done=0, sum=0, c_out=0, shift registers, carry flop and bit counter cleared. rst has priority over every other input.
- Internal registers:
  - sh_a, sh_b: WIDTH-bit shift registers.
  - carry: 1 bit.
  - acc: WIDTH-bit result shift register.
  - cnt: max(1, clog2(WIDTH)) bits.
- Full_adder connections: a=sh_a[0], b=sh_b[0], c_in=carry. The cell is purely combinational.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: sh_a<=op_a, sh_b<=op_b, carry<=c_in, cnt<=0, go to RUN.
  - sum and c_out are not altered.
- RUN (one bit per edge):
  - acc<={fa.sum, acc[WIDTH-1:1]}.
  - sh_a and sh_b shift right by 1, with 0 filled in.
  - carry<=fa.c_out, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<={fa.sum, acc[WIDTH-1:1]}, c_out<=fa.c_out, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH; done is high in the cycle following E_WIDTH; IDLE again after E_WIDTH+1.
  - Throughput: one operation per WIDTH+2 cycles.
  - busy is high from after E0 through the done cycle.
- start while busy=1 (RUN or DONE) is ignored and does not queue. A start held high is re-accepted in the first IDLE cycle after done.
- Operand changes after the accepting edge have no effect on the in-flight operation.
- Result arithmetic is modulo 2^WIDTH; c_out is bit WIDTH of op_a+op_b+c_in.
- WIDTH=1: exactly one RUN cycle, and the cnt==0 terminal condition holds on the first RUN edge.
- Reset mid-operation (RUN or DONE): operation aborted. The next cycle has busy=0 and done=0, sum and c_out are 0, and no done pulse is ever produced for the aborted request.
- busy, done, sum and c_out are all registered outputs. There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, c_out=0; no operation starts during reset.
2. WIDTH=8, op_a=0x0F, op_b=0x01, c_in=0, one-cycle start pulse -> busy high for 9 cycles; done high exactly 8 edges after the accepting edge, for 1 cycle; sum=0x10, c_out=0.
3. Carry ripple, run back-to-back:
   - 0xFF+0x01, c_in=0 -> sum=0x00, c_out=1.
   - 0xFF+0xFF, c_in=1 -> sum=0xFF, c_out=1.
   - 0xA5+0x5A, c_in=0 -> sum=0xFF, c_out=0.
4. Hold start=1 continuously, changing op_a/op_b every cycle while busy -> only values present at the IDLE accepting edges are used; exactly one done per WIDTH+2 cycles; sum/c_out unchanged between done pulses.
5. rst=1 on the 4th RUN cycle of 0x0F+0x01 -> next cycle busy=0, done=0, sum=0x00, c_out=0; no done pulse follows; a subsequent start completes correctly.
6. WIDTH=1, all 8 (op_a, op_b, c_in) combinations -> {c_out, sum} equals the 1-bit full-adder truth table (e.g. 1,1,1 -> sum=1, c_out=1); done 1 edge after accept.
